// File: rtl/vin_pixpacker.sv
// Pixel packer behind the input color mixer: quantizes luma pairs to 4 bpp,
// packs 16 pixels per 64-bit word and queues words in a small FWFT FIFO.
module vin_pixpacker #(
  parameter int FIFO_DEPTH = 4,
  parameter int ROUND      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_vsync,
  input  logic        in_hsync,
  input  logic [15:0] in_color,
  input  logic        in_valid,
  output logic [63:0] out_data,
  output logic        out_sof,
  output logic        out_eol,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  function automatic logic [3:0] quant(input logic [7:0] y);
    logic [4:0] r;
    r = 5'(({1'b0, y} + 9'd8) >> 4);
    if (ROUND != 0) return r[4] ? 4'hF : r[3:0];
    else            return y[7:4];
  endfunction

  logic [2:0]    beat_cnt, cnt_n;
  logic [3:0]    cnt_beat;
  logic [63:0]   acc, acc_beat, acc_n;
  logic [7:0]    beat_byte;
  logic          sof_pending, sof_n;
  logic          hs_last, vs_last;
  logic          line_word, line_n;
  logic          vs_rise, hs_rise;
  logic          push, push_eol, push_ok, drop, retag, pop;
  logic          empty, full, tail_kept;
  logic [PW-1:0] wr_ptr, rd_ptr, count;
  logic [AW-1:0] wr_idx, rd_idx, tail_idx;

  logic [63:0]           data_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] sof_mem, eol_mem;

  assign count     = wr_ptr - rd_ptr;
  assign empty     = (count == '0);
  assign full      = (count == PW'(FIFO_DEPTH));
  assign pop       = !empty && out_ready;
  assign wr_idx    = wr_ptr[AW-1:0];
  assign rd_idx    = rd_ptr[AW-1:0];
  assign tail_idx  = wr_idx - AW'(1);
  // The most recent word survives this cycle unless it is the only one and leaves now.
  assign tail_kept = !empty && !(pop && count == PW'(1));

  assign vs_rise   = in_vsync && !vs_last;
  assign hs_rise   = in_hsync && !hs_last;
  assign beat_byte = {quant(in_color[15:8]), quant(in_color[7:0])};
  assign cnt_beat  = {1'b0, beat_cnt} + 4'(in_valid);

  // Beat k lands in byte k counted from the MSB; unfilled bytes stay zero.
  always_comb begin
    acc_beat = acc;
    if (in_valid) begin
      for (int k = 0; k < 8; k++) begin
        if (beat_cnt == 3'(k)) acc_beat[63-8*k -: 8] = beat_byte;
      end
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    push     = 1'b0;
    push_eol = 1'b0;
    retag    = 1'b0;
    acc_n    = acc_beat;
    cnt_n    = cnt_beat[2:0];
    sof_n    = sof_pending;
    line_n   = line_word;

    if (vs_rise) begin
      acc_n  = '0;
      cnt_n  = '0;
      sof_n  = 1'b1;
      line_n = 1'b0;
    end else if (hs_rise) begin
      acc_n  = '0;
      cnt_n  = '0;
      line_n = 1'b0;
      if (cnt_beat != '0) begin
        push     = 1'b1;
        push_eol = 1'b1;
      end else if (line_word && tail_kept) begin
        retag = 1'b1;
      end
    end else if (cnt_beat[3]) begin
      push  = 1'b1;
      acc_n = '0;
    end

    if (push) sof_n = 1'b0;

    push_ok = push && (!full || pop);
    drop    = push && !push_ok;
    if (push_ok && !push_eol) line_n = 1'b1;
    if (drop)                 line_n = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt    <= '0;
      acc         <= '0;
      sof_pending <= 1'b1;
      line_word   <= 1'b0;
      hs_last     <= 1'b0;
      vs_last     <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow    <= 1'b0;
    end else begin
      beat_cnt    <= cnt_n;
      acc         <= acc_n;
      sof_pending <= sof_n;
      line_word   <= line_n;
      hs_last     <= in_hsync;
      vs_last     <= in_vsync;
      wr_ptr      <= wr_ptr + PW'(push_ok);
      rd_ptr      <= rd_ptr + PW'(pop);
      if (vs_rise)   overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end

  // NOTE: the storage array is not reset; outputs are gated by out_valid so stale entries never show.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      data_mem[wr_idx] <= acc_beat;
      sof_mem[wr_idx]  <= sof_pending;
      eol_mem[wr_idx]  <= push_eol;
    end else if (retag) begin
      eol_mem[tail_idx] <= 1'b1;
    end
  end

  assign out_valid = !empty;
  assign out_data  = out_valid ? data_mem[rd_idx] : '0;
  assign out_sof   = out_valid && sof_mem[rd_idx];
  assign out_eol   = out_valid && eol_mem[rd_idx];

endmodule
